bcd_score_keeper: RTL and testbench

Parametrised successor to the two-digit hit counter in the breakout top level. It keeps an N-digit packed-BCD score with per-event point values and selectable wrap or saturate at overflow. It also keeps a lives counter with game-over detection and a high-score register. Sits between pong_graph (hit/miss pulses) and Seg7Device (32-bit display word).

---
 rtl/bcd_score_keeper_if.sv | 27 ++
 rtl/bcd_score_keeper.sv | 119 +++++++++++
 tb/tb_bcd_score_keeper.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_score_keeper_if.sv
// Game-side bundle for bcd_score_keeper: event inputs from the playfield
// logic and the score/lives/display outputs toward the 7-segment driver.
interface bcd_score_keeper_if #(
   parameter int DIGITS = 4
);
   logic                  clr;
   logic                  hit;
   logic [3:0]            pts;
   logic                  miss;
   logic                  disp_sel;
   logic [4*DIGITS-1:0]   score;
   logic [4*DIGITS-1:0]   high;
   logic [3:0]            lives;
   logic                  game_over;
   logic                  new_high;
   logic [31:0]           seg_data;

   modport master (
      output clr, hit, pts, miss, disp_sel,
      input  score, high, lives, game_over, new_high, seg_data
   );

   modport slave (
      input  clr, hit, pts, miss, disp_sel,
      output score, high, lives, game_over, new_high, seg_data
   );
endinterface

// File: rtl/bcd_score_keeper.sv
// N-digit packed-BCD score keeper with lives, game-over detection and a
// high-score register; edges on hit/miss are detected internally.
module bcd_score_keeper #(
   parameter int DIGITS = 4,
   parameter int LIVES  = 3,
   parameter int WRAP   = 1
) (
   input logic                 clk,
   input logic                 reset,
   bcd_score_keeper_if.slave   bus
);
   localparam int         SW         = 4 * DIGITS;
   localparam logic [3:0] LIVES_INIT = 4'(LIVES);

   logic            r_hit_d;
   logic            r_miss_d;
   logic [SW-1:0]   r_score;
   logic [SW-1:0]   r_high;
   logic [3:0]      r_lives;
   logic            r_game_over;
   logic            r_new_high;

   logic            w_hit_e;
   logic            w_miss_e;
   logic [3:0]      w_pts;
   logic [SW:0]     w_sum;
   logic [SW-1:0]   w_add_score;
   logic [SW-1:0]   w_score_nxt;
   logic            w_last_miss;
   logic [SW-1:0]   w_sel;

   function automatic logic [3:0] clamp_pts(input logic [3:0] p);
      return (p > 4'd9) ? 4'd9 : p;
   endfunction

   // Returns {carry_out, sum}; decimal carry ripples from digit 0 upward.
   function automatic logic [SW:0] bcd_add(input logic [SW-1:0] a, input logic [3:0] p);
      logic [4:0]    s;
      logic          c;
      logic [SW-1:0] r;
      c = 1'b0;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         s = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, p} : 5'd0) + {4'd0, c};
         if (s > 5'd9) begin
            r[4*i +: 4] = 4'(s - 5'd10);
            c = 1'b1;
         end else begin
            r[4*i +: 4] = s[3:0];
            c = 1'b0;
         end
      end
      return {c, r};
   endfunction

   function automatic logic [SW-1:0] bcd_saturate(input logic [SW:0] s);
      if (s[SW] && (WRAP == 0))
         return {DIGITS{4'h9}};
      return s[SW-1:0];
   endfunction

   assign w_hit_e     = bus.hit & ~r_hit_d;
   assign w_miss_e    = bus.miss & ~r_miss_d;
   assign w_pts       = clamp_pts(bus.pts);
   assign w_sum       = bcd_add(r_score, w_pts);
   assign w_add_score = bcd_saturate(w_sum);
   assign w_score_nxt = w_hit_e ? w_add_score : r_score;
   assign w_last_miss = w_miss_e && (r_lives == 4'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_d     <= 1'b0;
         r_miss_d    <= 1'b0;
         r_score     <= '0;
         r_high      <= '0;
         r_lives     <= LIVES_INIT;
         r_game_over <= 1'b0;
         r_new_high  <= 1'b0;
      end else begin
         r_hit_d    <= bus.hit;
         r_miss_d   <= bus.miss;
         r_new_high <= 1'b0;
         if (bus.clr) begin
            r_score     <= '0;
            r_lives     <= LIVES_INIT;
            r_game_over <= 1'b0;
         end else if (!r_game_over) begin
            r_score <= w_score_nxt;
            if (w_miss_e && (r_lives > 4'd1)) begin
               r_lives <= r_lives - 4'd1;
            end else if (w_last_miss) begin
               r_lives     <= 4'd0;
               r_game_over <= 1'b1;
               // Packed BCD orders the same as unsigned binary.
               if (w_score_nxt > r_high) begin
                  r_high     <= w_score_nxt;
                  r_new_high <= 1'b1;
               end
            end
         end
      end
   end

   assign w_sel = bus.disp_sel ? r_high : r_score;

   generate
      if (SW == 32) begin : g_full
         assign bus.seg_data = w_sel;
      end else begin : g_pad
         assign bus.seg_data = {{(32-SW){1'b0}}, w_sel};
      end
   endgenerate

   assign bus.score     = r_score;
   assign bus.high      = r_high;
   assign bus.lives     = r_lives;
   assign bus.game_over = r_game_over;
   assign bus.new_high  = r_new_high;
endmodule

// File: tb/tb_bcd_score_keeper.sv
// Directed bench for bcd_score_keeper: a 4-digit wrapping instance plus
// 2-digit wrap and saturate instances driven in lockstep.
module tb_bcd_score_keeper;
   logic clk;
   logic reset;
   logic rst2;
   int   n_checks;
   int   n_errors;

   bcd_score_keeper_if #(.DIGITS(4)) m_if();
   bcd_score_keeper_if #(.DIGITS(2)) a_if();
   bcd_score_keeper_if #(.DIGITS(2)) b_if();

   bcd_score_keeper #(.DIGITS(4), .LIVES(3), .WRAP(1)) u_main (
      .clk(clk), .reset(reset), .bus(m_if));
   bcd_score_keeper #(.DIGITS(2), .LIVES(3), .WRAP(1)) u_wrap (
      .clk(clk), .reset(rst2), .bus(a_if));
   bcd_score_keeper #(.DIGITS(2), .LIVES(3), .WRAP(0)) u_sat (
      .clk(clk), .reset(rst2), .bus(b_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_hit(input logic [3:0] p);
      m_if.hit = 1'b1;
      m_if.pts = p;
      tick();
      m_if.hit = 1'b0;
      tick();
   endtask

   task automatic pulse_miss();
      m_if.miss = 1'b1;
      tick();
      m_if.miss = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse2(input logic [3:0] p);
      a_if.hit = 1'b1; b_if.hit = 1'b1;
      a_if.pts = p;    b_if.pts = p;
      tick();
      a_if.hit = 1'b0; b_if.hit = 1'b0;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0;
      rst2  = 1'b0;
      m_if.clr = 1'b0; m_if.hit = 1'b0; m_if.pts = 4'd0; m_if.miss = 1'b0; m_if.disp_sel = 1'b0;
      a_if.clr = 1'b0; a_if.hit = 1'b0; a_if.pts = 4'd0; a_if.miss = 1'b0; a_if.disp_sel = 1'b0;
      b_if.clr = 1'b0; b_if.hit = 1'b0; b_if.pts = 4'd0; b_if.miss = 1'b0; b_if.disp_sel = 1'b0;

      // Reset state
      do_reset();
      chk("rst_score", 32'(m_if.score), 32'h0);
      chk("rst_high", 32'(m_if.high), 32'h0);
      chk("rst_lives", 32'(m_if.lives), 32'd3);
      chk("rst_go", 32'(m_if.game_over), 32'd0);
      chk("rst_nh", 32'(m_if.new_high), 32'd0);

      // Twelve single-point hits, then one long hold counts once
      for (int i = 0; i < 12; i++) pulse_hit(4'd1);
      chk("s1_score", 32'(m_if.score), 32'h0012);
      chk("s1_lives", 32'(m_if.lives), 32'd3);
      chk("s1_go", 32'(m_if.game_over), 32'd0);
      m_if.hit = 1'b1;
      m_if.pts = 4'd1;
      tick();
      chk("s1_latency", 32'(m_if.score), 32'h0013);
      repeat (4) tick();
      m_if.hit = 1'b0;
      tick();
      chk("s1_hold", 32'(m_if.score), 32'h0013);

      // Two-digit wrap and saturate
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      for (int i = 0; i < 10; i++) pulse2(4'd9);
      pulse2(4'd5);
      chk("s2_wrap_95", 32'(a_if.score), 32'h95);
      chk("s2_sat_95", 32'(b_if.score), 32'h95);
      pulse2(4'd7);
      chk("s2_wrap", 32'(a_if.score), 32'h02);
      chk("s2_sat", 32'(b_if.score), 32'h99);
      pulse2(4'd3);
      chk("s2_wrap2", 32'(a_if.score), 32'h05);
      chk("s2_sat2", 32'(b_if.score), 32'h99);
      chk("s2_seg", b_if.seg_data, 32'h00000099);

      // Points clamp and zero-point hit
      do_reset();
      pulse_hit(4'd5);
      chk("s3_base", 32'(m_if.score), 32'h0005);
      pulse_hit(4'hC);
      chk("s3_clamp", 32'(m_if.score), 32'h0014);
      pulse_hit(4'd0);
      chk("s3_zero", 32'(m_if.score), 32'h0014);

      // Lives countdown to game over
      do_reset();
      pulse_hit(4'd9); pulse_hit(4'd9); pulse_hit(4'd9); pulse_hit(4'd3);
      chk("s4_score", 32'(m_if.score), 32'h0030);
      pulse_miss();
      chk("s4_lives2", 32'(m_if.lives), 32'd2);
      pulse_miss();
      chk("s4_lives1", 32'(m_if.lives), 32'd1);
      chk("s4_go_early", 32'(m_if.game_over), 32'd0);
      m_if.miss = 1'b1;
      tick();
      chk("s4_lives0", 32'(m_if.lives), 32'd0);
      chk("s4_go", 32'(m_if.game_over), 32'd1);
      chk("s4_high", 32'(m_if.high), 32'h0030);
      chk("s4_nh_on", 32'(m_if.new_high), 32'd1);
      m_if.miss = 1'b0;
      tick();
      chk("s4_nh_off", 32'(m_if.new_high), 32'd0);
      pulse_hit(4'd5);
      pulse_miss();
      chk("s4_frozen_score", 32'(m_if.score), 32'h0030);
      chk("s4_frozen_lives", 32'(m_if.lives), 32'd0);

      // Simultaneous hit and final miss, then clr and a lower second game
      do_reset();
      pulse_miss(); pulse_miss();
      pulse_hit(4'd8);
      chk("s5_pre", 32'(m_if.score), 32'h0008);
      m_if.hit = 1'b1; m_if.pts = 4'd3; m_if.miss = 1'b1;
      tick();
      chk("s5_score", 32'(m_if.score), 32'h0011);
      chk("s5_go", 32'(m_if.game_over), 32'd1);
      chk("s5_high", 32'(m_if.high), 32'h0011);
      chk("s5_nh", 32'(m_if.new_high), 32'd1);
      m_if.hit = 1'b0; m_if.miss = 1'b0;
      tick();
      m_if.clr = 1'b1;
      tick();
      m_if.clr = 1'b0;
      chk("s5_clr_score", 32'(m_if.score), 32'h0);
      chk("s5_clr_lives", 32'(m_if.lives), 32'd3);
      chk("s5_clr_go", 32'(m_if.game_over), 32'd0);
      chk("s5_clr_high", 32'(m_if.high), 32'h0011);
      tick();
      pulse_hit(4'd9);
      pulse_miss(); pulse_miss();
      m_if.miss = 1'b1;
      tick();
      chk("s5_g2_go", 32'(m_if.game_over), 32'd1);
      chk("s5_g2_score", 32'(m_if.score), 32'h0009);
      chk("s5_g2_high", 32'(m_if.high), 32'h0011);
      chk("s5_g2_nh", 32'(m_if.new_high), 32'd0);
      m_if.miss = 1'b0;
      tick();

      // clr beats a same-cycle hit; display mux; reset clears high
      m_if.clr = 1'b1; m_if.hit = 1'b1; m_if.pts = 4'd5;
      tick();
      m_if.clr = 1'b0; m_if.hit = 1'b0;
      tick();
      chk("s6_clr_hit", 32'(m_if.score), 32'h0);
      pulse_hit(4'd2);
      chk("s6_seg_score", m_if.seg_data, 32'h00000002);
      m_if.disp_sel = 1'b1;
      #1;
      chk("s6_seg_high", m_if.seg_data, 32'h00000011);
      do_reset();
      chk("s6_rst_high", 32'(m_if.high), 32'h0);
      chk("s6_rst_seg", m_if.seg_data, 32'h00000000);
      chk("s6_rst_lives", 32'(m_if.lives), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
